// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port, double-buffered frame RAM between
// VGA scanout and the median-filter engine.
//  - Scanout reads the front bank during active video and always wins.
//  - The filter may read or write the back bank only during blanking.
//  - The banks swap at the falling edge of vsync, and only once the filter
//    has reported that the back-bank frame is complete.
module vga_fb_arbiter #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int AW    = 19,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_active,
    input  logic [9:0]    i_x,
    input  logic [8:0]    i_y,
    input  logic          i_vs,
    input  logic          i_flt_req,
    input  logic          i_flt_we,
    input  logic [AW-1:0] i_flt_addr,
    input  logic [DW-1:0] i_flt_wdata,
    input  logic          i_flt_frame_done,
    output logic          o_flt_gnt,
    output logic          o_flt_rvalid,
    output logic [DW-1:0] o_flt_rdata,
    output logic          o_pix_valid,
    output logic [DW-1:0] o_pix_data,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW:0]   o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_front_bank,
    output logic          o_swap,
    output logic [7:0]    o_frame_cnt,
    output logic          o_overrun
);

    // One bank has to hold a whole active frame.
    generate
        if (H_ACT * V_ACT > (1 << AW)) begin : g_bank_too_small
            $error("vga_fb_arbiter: H_ACT*V_ACT does not fit in 2**AW");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_WAIT_SWAP = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_vs_prev;
    logic          r_front;
    logic          r_swap;
    logic [7:0]    r_frame_cnt;
    logic          r_overrun;
    logic          r_pix_valid;
    logic          r_flt_rvalid;

    logic          w_vs_start;
    logic          w_swap;
    logic          w_gnt;
    logic [AW-1:0] w_pix_addr;

    // Falling edge of the active-low vsync marks the start of vertical sync.
    assign w_vs_start = r_vs_prev & ~i_vs;

    // A swap happens on vsync start if a completed frame is pending, or if
    // completion arrives in that very cycle.
    assign w_swap = w_vs_start & ((r_state == ST_WAIT_SWAP) | i_flt_frame_done);

    // No grant while scanout is active, while a swap is pending, or in the
    // cycle the banks flip (the back bank is about to become the front).
    assign w_gnt = i_flt_req & ~i_active & (r_state == ST_RUN) & ~w_swap;

    // Linear scanout address within a bank; legal x,y never overflow AW bits.
    assign w_pix_addr = AW'(i_y) * AW'(H_ACT) + AW'(i_x);

    // Memory port mux: scanout first, then a granted filter access, else idle.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (i_active) begin
            o_mem_en   = 1'b1;
            o_mem_we   = 1'b0;
            o_mem_addr = {r_front, w_pix_addr};
        end else if (w_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_flt_we;
            o_mem_addr  = {~r_front, i_flt_addr};
            o_mem_wdata = i_flt_wdata;
        end else begin
            o_mem_en = 1'b0;
            o_mem_we = 1'b0;
        end
    end

    // Read-valid flags track the RAM's one-cycle read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_valid  <= 1'b0;
            r_flt_rvalid <= 1'b0;
        end else begin
            r_pix_valid  <= i_active;
            r_flt_rvalid <= w_gnt & ~i_flt_we;
        end
    end

    // Swap controller: waits for frame completion, flips banks on vsync start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_vs_prev   <= 1'b1;
            r_front     <= 1'b0;
            r_swap      <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_vs_prev <= i_vs;
            r_swap    <= w_swap;
            if (w_swap) begin
                r_front     <= ~r_front;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            case (r_state)
                ST_RUN: begin
                    if (i_flt_frame_done && !w_vs_start) begin
                        r_state <= ST_WAIT_SWAP;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (i_flt_frame_done) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_vs_start) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign o_flt_gnt    = w_gnt;
    assign o_flt_rvalid = r_flt_rvalid;
    assign o_flt_rdata  = i_mem_rdata;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_data   = i_mem_rdata;
    assign o_front_bank = r_front;
    assign o_swap       = r_swap;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural frame RAM.
// Unwritten RAM locations read back as the low byte of their address.
module tb_vga_fb_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          i_clk;
    logic          i_rst;
    logic          i_active;
    logic [9:0]    i_x;
    logic [8:0]    i_y;
    logic          i_vs;
    logic          i_flt_req;
    logic          i_flt_we;
    logic [AW-1:0] i_flt_addr;
    logic [DW-1:0] i_flt_wdata;
    logic          i_flt_frame_done;
    logic          o_flt_gnt;
    logic          o_flt_rvalid;
    logic [DW-1:0] o_flt_rdata;
    logic          o_pix_valid;
    logic [DW-1:0] o_pix_data;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW:0]   o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          o_front_bank;
    logic          o_swap;
    logic [7:0]    o_frame_cnt;
    logic          o_overrun;

    int n_tests;
    int n_fail;

    logic [DW-1:0] mem [0:(1 << (AW + 1)) - 1];

    vga_fb_arbiter #(.H_ACT(640), .V_ACT(480), .AW(AW), .DW(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_active(i_active), .i_x(i_x), .i_y(i_y),
        .i_vs(i_vs), .i_flt_req(i_flt_req), .i_flt_we(i_flt_we),
        .i_flt_addr(i_flt_addr), .i_flt_wdata(i_flt_wdata),
        .i_flt_frame_done(i_flt_frame_done), .o_flt_gnt(o_flt_gnt),
        .o_flt_rvalid(o_flt_rvalid), .o_flt_rdata(o_flt_rdata),
        .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_front_bank(o_front_bank), .o_swap(o_swap),
        .o_frame_cnt(o_frame_cnt), .o_overrun(o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Synchronous single-port RAM, read-before-write, one-cycle read latency.
    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
            i_mem_rdata <= mem[o_mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic set_in(input logic act, input logic [9:0] x, input logic [8:0] y,
                          input logic vs, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic fd);
        i_active = act; i_x = x; i_y = y; i_vs = vs;
        i_flt_req = req; i_flt_we = we; i_flt_addr = a; i_flt_wdata = d;
        i_flt_frame_done = fd;
        #1;
    endtask

    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = 8'(i);
        i_mem_rdata = 8'd0;

        // Reset
        i_rst = 1'b1;
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt(); nxt();
        i_rst = 1'b0;
        check_eq("rst_front", 32'(o_front_bank), 32'd0);
        check_eq("rst_swap", 32'(o_swap), 32'd0);
        check_eq("rst_cnt", 32'(o_frame_cnt), 32'd0);
        check_eq("rst_overrun", 32'(o_overrun), 32'd0);
        check_eq("rst_pix_valid", 32'(o_pix_valid), 32'd0);
        check_eq("rst_rvalid", 32'(o_flt_rvalid), 32'd0);

        // Line y=0: scanout owns the port, filter request never granted
        for (int x = 0; x < 640; x++) begin
            set_in(1'b1, 10'(x), 9'd0, 1'b1, 1'b1, 1'b1, 19'd9, 8'h11, 1'b0);
            check_eq("line0_gnt", 32'(o_flt_gnt), 32'd0);
            check_eq("line0_en", 32'(o_mem_en), 32'd1);
            check_eq("line0_we", 32'(o_mem_we), 32'd0);
            check_eq("line0_addr", 32'(o_mem_addr), 32'(x));
            if (x == 0) begin
                check_eq("line0_pv_first", 32'(o_pix_valid), 32'd0);
            end else begin
                check_eq("line0_pv", 32'(o_pix_valid), 32'd1);
                check_eq("line0_pdata", 32'(o_pix_data), 32'((x - 1) % 256));
            end
            nxt();
        end
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        check_eq("line0_pv_tail", 32'(o_pix_valid), 32'd1);
        check_eq("line0_pdata_tail", 32'(o_pix_data), 32'h7F);
        check_eq("blank_en", 32'(o_mem_en), 32'd0);
        nxt();
        check_eq("line0_pv_off", 32'(o_pix_valid), 32'd0);

        // Address arithmetic corners
        set_in(1'b1, 10'd5, 9'd2, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        check_eq("addr_y2x5", 32'(o_mem_addr), 32'd1285);
        nxt();
        set_in(1'b1, 10'd639, 9'd479, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        check_eq("addr_last", 32'(o_mem_addr), 32'd307199);
        nxt();

        // Blanking: filter write then read of back-bank addr 100
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 19'd100, 8'hA5, 1'b0);
        check_eq("wr_gnt", 32'(o_flt_gnt), 32'd1);
        check_eq("wr_we", 32'(o_mem_we), 32'd1);
        check_eq("wr_addr", 32'(o_mem_addr), 32'd524388);
        check_eq("wr_data", 32'(o_mem_wdata), 32'hA5);
        nxt();
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 19'd100, 8'h00, 1'b0);
        check_eq("rd_gnt", 32'(o_flt_gnt), 32'd1);
        check_eq("rd_we", 32'(o_mem_we), 32'd0);
        check_eq("rd_addr", 32'(o_mem_addr), 32'd524388);
        check_eq("rd_rvalid_early", 32'(o_flt_rvalid), 32'd0);
        nxt();
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        check_eq("rd_rvalid", 32'(o_flt_rvalid), 32'd1);
        check_eq("rd_rdata", 32'(o_flt_rdata), 32'hA5);
        nxt();
        check_eq("rd_rvalid_off", 32'(o_flt_rvalid), 32'd0);

        // Frame done mid-frame: grants blocked until vsync start, then swap
        set_in(1'b1, 10'd10, 9'd5, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b1);
        nxt();
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 19'd7, 8'h3C, 1'b0);
        check_eq("wait_gnt", 32'(o_flt_gnt), 32'd0);
        check_eq("wait_en", 32'(o_mem_en), 32'd0);
        nxt(); nxt();
        check_eq("wait_gnt2", 32'(o_flt_gnt), 32'd0);
        set_in(1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 19'd7, 8'h3C, 1'b0);
        check_eq("swapcyc_gnt", 32'(o_flt_gnt), 32'd0);
        check_eq("swapcyc_pulse", 32'(o_swap), 32'd0);
        nxt();
        check_eq("swap1_pulse", 32'(o_swap), 32'd1);
        check_eq("swap1_front", 32'(o_front_bank), 32'd1);
        check_eq("swap1_cnt", 32'(o_frame_cnt), 32'd1);
        check_eq("swap1_gnt", 32'(o_flt_gnt), 32'd1);
        check_eq("swap1_flt_addr", 32'(o_mem_addr), 32'd7);
        nxt();
        check_eq("swap1_pulse_off", 32'(o_swap), 32'd0);
        set_in(1'b1, 10'd3, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        check_eq("swap1_scan_addr", 32'(o_mem_addr), 32'd524291);
        nxt();

        // Frame done coincident with vsync start: immediate swap
        set_in(1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b0, 19'd0, 8'd0, 1'b1);
        check_eq("coinc_gnt", 32'(o_flt_gnt), 32'd0);
        nxt();
        check_eq("coinc_swap", 32'(o_swap), 32'd1);
        check_eq("coinc_front", 32'(o_front_bank), 32'd0);
        check_eq("coinc_cnt", 32'(o_frame_cnt), 32'd2);
        set_in(1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b0, 19'd0, 8'd0, 1'b0);
        check_eq("coinc_run_gnt", 32'(o_flt_gnt), 32'd1);
        check_eq("coinc_flt_addr", 32'(o_mem_addr), 32'd524288);
        nxt();
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt();

        // Second frame done while waiting: sticky overrun
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b1);
        nxt();
        check_eq("ovr_before", 32'(o_overrun), 32'd0);
        nxt();
        check_eq("ovr_set", 32'(o_overrun), 32'd1);
        set_in(1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt();
        check_eq("ovr_swap", 32'(o_swap), 32'd1);
        check_eq("ovr_cnt", 32'(o_frame_cnt), 32'd3);
        check_eq("ovr_front", 32'(o_front_bank), 32'd1);
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt(); nxt();
        check_eq("ovr_sticky", 32'(o_overrun), 32'd1);

        // vsync start without pending frame: no swap
        set_in(1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt();
        check_eq("noswap_pulse", 32'(o_swap), 32'd0);
        check_eq("noswap_cnt", 32'(o_frame_cnt), 32'd3);
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt();

        // 253 more swaps -> 256 in total, counter wraps
        for (int i = 0; i < 253; i++) begin
            set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
            nxt();
            set_in(1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 19'd0, 8'd0, 1'b1);
            nxt();
        end
        check_eq("wrap_cnt", 32'(o_frame_cnt), 32'd0);
        check_eq("wrap_front", 32'(o_front_bank), 32'd0);
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt();

        // Reset while waiting for a swap, with a filter read in flight
        set_in(1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 19'd0, 8'd0, 1'b1);
        nxt();
        check_eq("pre_rst_cnt", 32'(o_frame_cnt), 32'd1);
        check_eq("pre_rst_front", 32'(o_front_bank), 32'd1);
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 19'd0, 8'd0, 1'b0);
        nxt();
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 19'd50, 8'd0, 1'b1);
        check_eq("pre_rst_gnt", 32'(o_flt_gnt), 32'd1);
        nxt();
        i_rst = 1'b1;
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 19'd50, 8'd0, 1'b0);
        check_eq("rst_wait_gnt", 32'(o_flt_gnt), 32'd0);
        check_eq("rst_inflight", 32'(o_flt_rvalid), 32'd1);
        nxt();
        i_rst = 1'b0;
        check_eq("rst2_front", 32'(o_front_bank), 32'd0);
        check_eq("rst2_cnt", 32'(o_frame_cnt), 32'd0);
        check_eq("rst2_rvalid", 32'(o_flt_rvalid), 32'd0);
        check_eq("rst2_overrun", 32'(o_overrun), 32'd0);
        set_in(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 19'd50, 8'd0, 1'b0);
        check_eq("rst2_gnt", 32'(o_flt_gnt), 32'd1);
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
